// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment code table, digit count, FSM encodings and digit-select helpers
package seven_seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [1:0] ST_WAIT_SEL = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  function automatic logic sel_valid(input logic [3:0] sel);
    logic [3:0] a;
    a = ~sel;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction
  function automatic logic [1:0] sel_idx(input logic [3:0] sel);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!sel[i]) idx = 2'(i);
    return idx;
  endfunction
endpackage

// File: rtl/seven_seg_reader_if.sv
// seven_seg_reader_if: display-side bus and frame outputs; dp exists only with SEVEN_SEG_READER_DP_EN
interface seven_seg_reader_if;
  logic [7:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  blank;
  logic        err;
`ifdef SEVEN_SEG_READER_DP_EN
  logic [3:0]  dp;
  modport master (output seg_in, dig_sel, input value, frame_valid, blank, err, dp);
  modport slave  (input seg_in, dig_sel, output value, frame_valid, blank, err, dp);
`else
  modport master (output seg_in, dig_sel, input value, frame_valid, blank, err);
  modport slave  (input seg_in, dig_sel, output value, frame_valid, blank, err);
`endif
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low segment pattern to nibble; bit7 ignored under SEVEN_SEG_READER_DP_EN
module seg7_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [7:0] i_pat,
  output logic [3:0] o_nibble,
  output logic       o_hit,
  output logic       o_is_blank
);
`ifdef SEVEN_SEG_READER_DP_EN
  localparam logic [7:0] CMP_MASK = 8'h7F;
`else
  localparam logic [7:0] CMP_MASK = 8'hFF;
`endif
  logic w_blank;
  assign w_blank = (i_pat | ~CMP_MASK) == BLANK;
  assign o_is_blank = w_blank;
  always_comb begin
    o_nibble = '0;
    o_hit = w_blank;
    for (int i = 0; i < 16; i++)
      if ((i_pat & CMP_MASK) == (SEG_TABLE[i] & CMP_MASK)) begin
        o_nibble = 4'(i);
        o_hit = 1'b1;
      end
  end
endmodule

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: captures a multiplexed 4-digit 7-seg display into 16-bit frames; SEVEN_SEG_READER_DP_EN adds dp
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYC = 4
) (
  input  logic       CLOCK_50,
  input  logic [0:0] SW,
  seven_seg_reader_if.slave bus
);
  logic        w_rst;
  logic [7:0]  r_seg_s1, r_seg_s2, r_seg_q;
  logic [3:0]  r_sel_s1, r_sel_s2, r_sel_q;
  logic [1:0]  r_state, w_state_nx;
  logic [7:0]  r_count, w_count_nx;
  logic [3:0]  r_mask, r_sh_blank, r_blank;
  logic [15:0] r_shadow, r_value;
  logic        r_fv, r_err;
  logic [3:0]  w_nibble;
  logic        w_hit, w_is_blank, w_valid, w_change, w_capture, w_frame;
  logic [1:0]  w_idx;
  assign w_rst = SW[0];
  seg7_pattern_decode u_dec (
    .i_pat      (r_seg_s2),
    .o_nibble   (w_nibble),
    .o_hit      (w_hit),
    .o_is_blank (w_is_blank)
  );
  assign w_valid   = sel_valid(r_sel_s2);
  assign w_idx     = sel_idx(r_sel_s2);
  assign w_change  = (r_seg_s2 != r_seg_q) || (r_sel_s2 != r_sel_q);
  assign w_capture = (r_state == ST_SETTLE) && w_valid && !w_change && (r_count == 8'(SETTLE_CYC - 1));
  assign w_frame   = r_mask == 4'hF;
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    if (!w_valid || r_state == ST_WAIT_SEL || w_change) begin
      w_state_nx = w_valid ? ST_SETTLE : ST_WAIT_SEL;
      w_count_nx = '0;
    end else if (r_state == ST_SETTLE) begin
      w_state_nx = w_capture ? ST_HOLD : ST_SETTLE;
      w_count_nx = w_capture ? r_count : r_count + 8'd1;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_q    <= '1;
      r_sel_s1   <= '1;
      r_sel_s2   <= '1;
      r_sel_q    <= '1;
      r_state    <= ST_WAIT_SEL;
      r_count    <= '0;
      r_mask     <= '0;
      r_shadow   <= '0;
      r_sh_blank <= '0;
      r_value    <= '0;
      r_blank    <= '0;
      r_fv       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_seg_s1 <= bus.seg_in;
      r_seg_s2 <= r_seg_s1;
      r_seg_q  <= r_seg_s2;
      r_sel_s1 <= bus.dig_sel;
      r_sel_s2 <= r_sel_s1;
      r_sel_q  <= r_sel_s2;
      r_state  <= w_state_nx;
      r_count  <= w_count_nx;
      // a recaptured digit just overwrites its shadow slot; the mask bit is idempotent
      r_mask   <= (w_frame ? 4'h0 : r_mask) | (w_capture && w_hit ? 4'b1 << w_idx : 4'h0);
      if (w_capture && w_hit) begin
        r_shadow[4*w_idx +: 4] <= w_nibble;
        r_sh_blank[w_idx]      <= w_is_blank;
      end
      if (w_capture && !w_hit) r_err <= 1'b1;
      r_fv <= w_frame;
      if (w_frame) begin
        r_value <= r_shadow;
        r_blank <= r_sh_blank;
      end
    end
  end
  assign bus.value       = r_value;
  assign bus.blank       = r_blank;
  assign bus.frame_valid = r_fv;
  assign bus.err         = r_err;
`ifdef SEVEN_SEG_READER_DP_EN
  logic [3:0] r_sh_dp, r_dp;
  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_sh_dp <= '0;
      r_dp    <= '0;
    end else begin
      if (w_capture && w_hit) r_sh_dp[w_idx] <= ~r_seg_s2[7];
      if (w_frame) r_dp <= r_sh_dp;
    end
  end
  assign bus.dp = r_dp;
`endif
endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader: directed scoreboard bench for seven_seg_reader with SETTLE_CYC=4
module tb_seven_seg_reader;
  logic       clk = 1'b0;
  logic [0:0] sw;
  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  seven_seg_reader_if bus ();
  seven_seg_reader #(.SETTLE_CYC(4)) dut (
    .CLOCK_50 (clk),
    .SW       (sw),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.frame_valid === 1'b1) begin
      fv_cnt++;
      obs_q.push_back({bus.blank, bus.value});
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic show(input int d, input logic [7:0] pat, input int n);
    bus.dig_sel = ~(4'b0001 << d);
    bus.seg_in  = pat;
    repeat (n) @(negedge clk);
  endtask
  task automatic check_frame(input string tag);
    logic [19:0] e, o;
    for (int n = 0; n < 100 && obs_q.size() == 0; n++) @(negedge clk);
    e = exp_q.pop_front();
    o = 'x;
    if (obs_q.size() != 0) o = obs_q.pop_front();
    chk(tag, {12'h0, o}, {12'h0, e});
  endtask
  initial begin
    sw = 1'b1;
    bus.seg_in  = 8'hFF;
    bus.dig_sel = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst.value", bus.value, 0);
    chk("rst.blank", bus.blank, 0);
    chk("rst.fv", bus.frame_valid, 0);
    chk("rst.err", bus.err, 0);
    sw = 1'b0;
    exp_q.push_back({4'b0000, 16'h120F});
    show(0, 8'h8E, 10);
    show(1, 8'hC0, 10);
    show(2, 8'hA4, 10);
    show(3, 8'hF9, 10);
    check_frame("basic.frame");
    chk("basic.err", bus.err, 0);
    exp_q.push_back({4'b0000, 16'h3510});
    show(0, 8'hC0, 10);
    show(1, 8'hF9, 10);
    show(3, 8'hB0, 10);
    show(2, 8'h99, 3);
    show(2, 8'h92, 10);
    check_frame("settle.frame");
    exp_q.push_back({4'b1000, 16'h0321});
    show(0, 8'hF9, 10);
    show(1, 8'hA4, 10);
    show(2, 8'hB0, 10);
    show(3, 8'hFF, 10);
    check_frame("blank.frame");
    show(0, 8'hC0, 10);
    show(1, 8'h7F, 10);
    chk("bad.err_set", bus.err, 1);
    show(2, 8'hA4, 10);
    show(3, 8'hB0, 10);
    chk("bad.noframe", obs_q.size(), 0);
    exp_q.push_back({4'b0000, 16'h3240});
    show(1, 8'h99, 10);
    check_frame("bad.frame");
    chk("bad.err_sticky", bus.err, 1);
    show(0, 8'hC0, 10);
    show(1, 8'hF9, 10);
    show(2, 8'hA4, 10);
    sw = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2.value", bus.value, 0);
    chk("rst2.blank", bus.blank, 0);
    chk("rst2.err", bus.err, 0);
    chk("rst2.fv", bus.frame_valid, 0);
    sw = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst2.noframe", obs_q.size(), 0);
    exp_q.push_back({4'b0000, 16'h9ABE});
    show(0, 8'h86, 10);
    show(1, 8'h83, 10);
    show(2, 8'h88, 10);
    show(3, 8'h90, 10);
    check_frame("rst2.frame");
    bus.dig_sel = 4'b1100;
    bus.seg_in  = 8'hC0;
    repeat (20) @(negedge clk);
    chk("twohot.err", bus.err, 0);
    show(1, 8'hF9, 10);
    show(2, 8'hA4, 10);
    show(3, 8'hB0, 10);
    chk("twohot.nocapture", obs_q.size(), 0);
    exp_q.push_back({4'b0000, 16'h3210});
    show(0, 8'hC0, 10);
    check_frame("twohot.frame");
    repeat (10) @(negedge clk);
    chk("fv.count", fv_cnt, 6);
    chk("fv.extra", obs_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4, the number of consecutive stable synchronized cycles required before a digit is captured (legal range 1..255).
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port SW, input, 1 bit: SW[0] is the reset, synchronous and active-high.
REQ-004 SHALL have port seg_in, input, 8 bits: active-low segment bus of the observed display (bit7 = DP, bits6:0 = g..a).
REQ-005 SHALL have port dig_sel, input, 4 bits: active-low digit enables; exactly one low selects digit 0..3.
REQ-006 SHALL have port value, output, 16 bits: last complete frame; digit n maps to value[4n+3:4n].
REQ-007 SHALL have port frame_valid, output, 1 bit: single-cycle pulse when value updates.
REQ-008 SHALL have port blank, output, 4 bits: per-digit flag, set when the last frame saw pattern 0xFF on that digit.
REQ-009 SHALL have port err, output, 1 bit: sticky flag for an unrecognized pattern, cleared only by reset.

Function
REQ-010 SHALL pass seg_in and dig_sel through a 2-flop synchronizer; all latencies below count from the synchronized signals.
REQ-011 SHALL decode with the table 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E; 0xFF = blank (nibble 0).
REQ-012 SHALL run the FSM states WAIT_SEL (no valid one-hot), SETTLE (counting stability) and HOLD (digit captured; waits for a change).
REQ-013 SHALL in WAIT_SEL go to SETTLE with the count cleared when dig_sel is a valid one-hot-low; otherwise stay.
REQ-014 SHALL in SETTLE clear the count and re-enter SETTLE on any change of seg_in or dig_sel, or go to WAIT_SEL if dig_sel becomes invalid; at count = SETTLE_CYC-1 it captures and goes to HOLD.
REQ-015 SHALL on capture write the nibble and blank bit into the shadow for the selected digit and set that digit's mask bit; an unrecognized pattern sets err and sets neither the mask nor the shadow.
REQ-016 SHALL in HOLD go to SETTLE on any change of dig_sel or seg_in, or to WAIT_SEL if dig_sel is invalid.
REQ-017 SHALL on the cycle after the capture that makes mask = 1111 load value and blank from the shadow (including that capture), pulse frame_valid, and clear the mask.
REQ-018 SHALL, when a digit is recaptured before the frame completes, let the newer nibble overwrite the shadow without double-counting it.
REQ-019 SHALL never generate frame_valid pulses on back-to-back cycles; the minimum spacing is 4*SETTLE_CYC cycles.

Reset
REQ-020 SHALL while SW[0]=1 at a clock edge set: value=0, blank=0, frame_valid=0, err=0, mask=0, shadow=0, count=0, state=WAIT_SEL, synchronizers=all ones.
REQ-021 SHALL, when reset is asserted mid-SETTLE or mid-frame, discard partial captures with no frame_valid pulse.

Configuration
REQ-022 SHALL, with macro SEVEN_SEG_READER_DP_EN defined, mask bit7 out of the table match and add output dp[3:0] (dp[n] = ~seg_in[7] at capture, loaded with the frame, reset 0).
REQ-023 SHALL, without SEVEN_SEG_READER_DP_EN, have no dp port and require bit7=1 for a match; bit7=0 is unrecognized (sets err).

Structure
REQ-024 SHALL place the 16-entry code table, the BLANK code 8'hFF, NUM_DIGITS=4 and the FSM state encodings in shared package seven_seg_pkg.
REQ-025 SHALL implement decoding in combinational sub-module seg7_pattern_decode (pattern -> nibble, hit, is_blank).

Verification
REQ-026 SHALL verify: with SETTLE_CYC=4, digits 0..3 driven with 8E,C0,A4,F9 (digit 0 first), each held 10 cycles -> one frame_valid, value=16'h120F, err=0.
REQ-027 SHALL verify: digit 2 held with 0x99 for only 3 stable cycles, then changed to 0x92 -> digit 2 captures 5, never 4.
REQ-028 SHALL verify: pattern 0x7F on digit 1 -> err=1 that cycle and onward; the frame completes only after a valid recapture of digit 1.
REQ-029 SHALL verify: digit 3 held with 0xFF in a full frame -> blank=4'b1000 and value[15:12]=0.
REQ-030 SHALL verify: SW[0] pulsed after 3 digits are captured -> no frame_valid, all outputs 0, and the next full frame is reported normally.
REQ-031 SHALL verify: dig_sel=4'b1100 (two low) for 20 cycles -> FSM stays in WAIT_SEL with no capture and no err.
